// File: rtl/led_marquee.sv
// Circular LED bar marquee: rotates left/right or bounces a bar of len_q lit LEDs.
// One step is taken every DIV enabled cycles; wrap pulses on wrap-around or reversal.
module led_marquee #(
  parameter int WIDTH = 16,
  parameter int DIV   = 1,
  localparam int LW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [LW-1:0]    len,
  input  logic [1:0]       mode,
  input  logic             load,
  output logic [WIDTH-1:0] led,
  output logic             wrap
);

  localparam int PW = $clog2(WIDTH);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] POS_MAX = PW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  dir_t             r_dir, w_dir_nxt;
  logic [PW-1:0]    r_pos, w_pos_nxt;
  logic [LW-1:0]    r_len_q, w_eff_len, w_top;
  logic [CW-1:0]    r_cnt;
  logic             w_step, w_wrap_nxt, w_wrap_out;
  logic [WIDTH-1:0] w_led_nxt;

  // Bar of n lit LEDs starting at p, wrapping around the top end.
  function automatic logic [WIDTH-1:0] bar(input logic [LW-1:0] n, input logic [PW-1:0] p);
    logic [WIDTH-1:0]   m;
    logic [2*WIDTH-1:0] t;
    m = '0;
    for (int unsigned i = 0; i < WIDTH; i++)
      if (i < 32'(n)) m[i] = 1'b1;
    t = {{WIDTH{1'b0}}, m} << p;
    return t[WIDTH-1:0] | t[2*WIDTH-1:WIDTH];
  endfunction

  always_comb begin
    if (len == '0)
      w_eff_len = LW'(1);
    else if (len > LW'(WIDTH))
      w_eff_len = LW'(WIDTH);
    else
      w_eff_len = len;
  end

  assign w_top  = LW'(WIDTH) - r_len_q;
  assign w_step = en && (mode != 2'b11) && (r_cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_dir <= DIR_UP;
    else if (load)
      r_dir <= DIR_UP;
    else
      r_dir <= w_dir_nxt;
  end

  always_comb begin
    w_pos_nxt  = r_pos;
    w_dir_nxt  = r_dir;
    w_wrap_nxt = 1'b0;
    if (w_step) begin
      case (mode)
        2'b00: begin
          if (r_pos == POS_MAX) begin
            w_pos_nxt  = '0;
            w_wrap_nxt = 1'b1;
          end else begin
            w_pos_nxt = r_pos + PW'(1);
          end
        end
        2'b01: begin
          if (r_pos == '0) begin
            w_pos_nxt  = POS_MAX;
            w_wrap_nxt = 1'b1;
          end else begin
            w_pos_nxt = r_pos - PW'(1);
          end
        end
        2'b10: begin
          // Full-width bar has no room to travel: pin it and report a reversal each step.
          if (w_top == '0) begin
            w_pos_nxt  = '0;
            w_wrap_nxt = 1'b1;
          end else if (LW'(r_pos) > w_top) begin
            w_pos_nxt  = PW'(w_top);
            w_dir_nxt  = DIR_DOWN;
            w_wrap_nxt = 1'b1;
          end else if (r_dir == DIR_UP) begin
            if (LW'(r_pos) == w_top) begin
              w_pos_nxt  = r_pos - PW'(1);
              w_dir_nxt  = DIR_DOWN;
              w_wrap_nxt = 1'b1;
            end else begin
              w_pos_nxt = r_pos + PW'(1);
            end
          end else begin
            if (r_pos == '0) begin
              w_pos_nxt  = PW'(1);
              w_dir_nxt  = DIR_UP;
              w_wrap_nxt = 1'b1;
            end else begin
              w_pos_nxt = r_pos - PW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_led_nxt  = bar(r_len_q, w_pos_nxt);
    w_wrap_out = w_wrap_nxt;
    if (load) begin
      w_led_nxt  = bar(w_eff_len, '0);
      w_wrap_out = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pos   <= '0;
      r_cnt   <= '0;
      r_len_q <= w_eff_len;
      led     <= bar(w_eff_len, '0);
      wrap    <= 1'b0;
    end else begin
      if (load) begin
        r_pos   <= '0;
        r_cnt   <= '0;
        r_len_q <= w_eff_len;
      end else begin
        r_pos <= w_pos_nxt;
        if (en && (mode != 2'b11))
          r_cnt <= w_step ? '0 : r_cnt + CW'(1);
      end
      led  <= w_led_nxt;
      wrap <= w_wrap_out;
    end
  end

endmodule

// File: tb/tb_led_marquee.sv
// Directed bench for led_marquee: WIDTH=16 with DIV=1 and DIV=4 instances on shared stimulus.
module tb_led_marquee;

  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [4:0]  len;
  logic [1:0]  mode;
  logic [15:0] led, led4;
  logic        wrap, wrap4;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  led_marquee #(.WIDTH(16), .DIV(1)) dut (
    .clk(clk), .rst(rst), .en(en), .len(len), .mode(mode), .load(load),
    .led(led), .wrap(wrap)
  );

  led_marquee #(.WIDTH(16), .DIV(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .len(len), .mode(mode), .load(load),
    .led(led4), .wrap(wrap4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [4:0] l);
    en   = 1'b0;
    mode = 2'b00;
    load = 1'b0;
    len  = l;
    rst  = 1'b1;
    tick();
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b0; mode = 2'b00; load = 1'b0; len = 5'd3; rst = 1'b1;
    tick();
    if (led !== 16'h0007) begin miscompares++; $display("FAIL reset_len3 led=%h expected=%h", led, 16'h0007); end
    vectors++;
    if (wrap !== 1'b0) begin miscompares++; $display("FAIL reset_wrap wrap=%b expected=0", wrap); end
    vectors++;
    len = 5'd0;
    tick();
    if (led !== 16'h0001) begin miscompares++; $display("FAIL reset_len0 led=%h expected=%h", led, 16'h0001); end
    vectors++;
    len = 5'd20;
    tick();
    if (led !== 16'hFFFF) begin miscompares++; $display("FAIL reset_len20 led=%h expected=%h", led, 16'hFFFF); end
    vectors++;
    if (led4 !== 16'hFFFF) begin miscompares++; $display("FAIL reset_len20_div4 led=%h expected=%h", led4, 16'hFFFF); end
    vectors++;
    rst = 1'b0;
  endtask

  task automatic test_rotate_left();
    logic [15:0] exp_led;
    logic        chk;
    do_reset(5'd3);
    len  = 5'd7;  // ignored until the next load/reset
    mode = 2'b00;
    en   = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk = 1'b1;
      case (k)
        1:       exp_led = 16'h000E;
        13:      exp_led = 16'hE000;
        14:      exp_led = 16'hC001;
        16:      exp_led = 16'h0007;
        default: begin exp_led = '0; chk = 1'b0; end
      endcase
      if (chk) begin
        if (led !== exp_led) begin miscompares++; $display("FAIL rotl_step%0d led=%h expected=%h", k, led, exp_led); end
        vectors++;
      end
      if (wrap !== (k == 16)) begin miscompares++; $display("FAIL rotl_wrap_step%0d wrap=%b expected=%b", k, wrap, (k == 16)); end
      vectors++;
    end
  endtask

  task automatic test_rotate_right();
    do_reset(5'd4);
    mode = 2'b01;
    en   = 1'b1;
    tick();
    if (led !== 16'h8007) begin miscompares++; $display("FAIL rotr_step1 led=%h expected=%h", led, 16'h8007); end
    vectors++;
    if (wrap !== 1'b1) begin miscompares++; $display("FAIL rotr_wrap1 wrap=%b expected=1", wrap); end
    vectors++;
    tick();
    if (led !== 16'hC003) begin miscompares++; $display("FAIL rotr_step2 led=%h expected=%h", led, 16'hC003); end
    vectors++;
    if (wrap !== 1'b0) begin miscompares++; $display("FAIL rotr_wrap2 wrap=%b expected=0", wrap); end
    vectors++;
  endtask

  task automatic test_bounce();
    logic [15:0] exp_led;
    logic        chk;
    do_reset(5'd4);
    mode = 2'b10;
    en   = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      chk = 1'b1;
      case (k)
        12:      exp_led = 16'hF000;
        13:      exp_led = 16'h7800;
        24:      exp_led = 16'h000F;
        25:      exp_led = 16'h001E;
        default: begin exp_led = '0; chk = 1'b0; end
      endcase
      if (chk) begin
        if (led !== exp_led) begin miscompares++; $display("FAIL bounce_step%0d led=%h expected=%h", k, led, exp_led); end
        vectors++;
      end
      if (wrap !== (k == 13 || k == 25)) begin miscompares++; $display("FAIL bounce_wrap_step%0d wrap=%b expected=%b", k, wrap, (k == 13 || k == 25)); end
      vectors++;
    end
  endtask

  task automatic test_bounce_full();
    do_reset(5'd16);
    mode = 2'b10;
    en   = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (led !== 16'hFFFF) begin miscompares++; $display("FAIL bfull_step%0d led=%h expected=%h", k, led, 16'hFFFF); end
      vectors++;
      if (wrap !== 1'b1) begin miscompares++; $display("FAIL bfull_wrap_step%0d wrap=%b expected=1", k, wrap); end
      vectors++;
    end
  endtask

  task automatic test_clamp();
    do_reset(5'd4);
    mode = 2'b00;
    en   = 1'b1;
    for (int k = 1; k <= 14; k++) tick();
    if (led !== 16'hC003) begin miscompares++; $display("FAIL clamp_pre led=%h expected=%h", led, 16'hC003); end
    vectors++;
    mode = 2'b10;
    tick();
    if (led !== 16'hF000) begin miscompares++; $display("FAIL clamp_step led=%h expected=%h", led, 16'hF000); end
    vectors++;
    if (wrap !== 1'b1) begin miscompares++; $display("FAIL clamp_wrap wrap=%b expected=1", wrap); end
    vectors++;
    tick();
    if (led !== 16'h7800) begin miscompares++; $display("FAIL clamp_down led=%h expected=%h", led, 16'h7800); end
    vectors++;
    if (wrap !== 1'b0) begin miscompares++; $display("FAIL clamp_down_wrap wrap=%b expected=0", wrap); end
    vectors++;
  endtask

  task automatic test_divider();
    logic [15:0] exp_led;
    do_reset(5'd1);
    mode = 2'b00;
    en   = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      exp_led = (e < 4) ? 16'h0001 : 16'h0002;
      if (led4 !== exp_led) begin miscompares++; $display("FAIL div_a_edge%0d led=%h expected=%h", e, led4, exp_led); end
      vectors++;
    end
    en = 1'b0;
    for (int e = 1; e <= 2; e++) begin
      tick();
      if (led4 !== 16'h0002) begin miscompares++; $display("FAIL div_en0_edge%0d led=%h expected=%h", e, led4, 16'h0002); end
      vectors++;
    end
    en = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      exp_led = (e < 4) ? 16'h0002 : 16'h0004;
      if (led4 !== exp_led) begin miscompares++; $display("FAIL div_b_edge%0d led=%h expected=%h", e, led4, exp_led); end
      vectors++;
    end
    mode = 2'b11;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (led4 !== 16'h0004) begin miscompares++; $display("FAIL div_hold_edge%0d led=%h expected=%h", e, led4, 16'h0004); end
      vectors++;
    end
    mode = 2'b00;
    for (int e = 1; e <= 4; e++) begin
      tick();
      exp_led = (e < 4) ? 16'h0004 : 16'h0008;
      if (led4 !== exp_led) begin miscompares++; $display("FAIL div_c_edge%0d led=%h expected=%h", e, led4, exp_led); end
      vectors++;
    end
  endtask

  task automatic test_load();
    do_reset(5'd2);
    mode = 2'b00;
    en   = 1'b1;
    for (int k = 1; k <= 9; k++) tick();
    if (led !== 16'h0600) begin miscompares++; $display("FAIL load_pre led=%h expected=%h", led, 16'h0600); end
    vectors++;
    len  = 5'd5;
    load = 1'b1;
    tick();
    if (led !== 16'h001F) begin miscompares++; $display("FAIL load_led led=%h expected=%h", led, 16'h001F); end
    vectors++;
    if (wrap !== 1'b0) begin miscompares++; $display("FAIL load_wrap wrap=%b expected=0", wrap); end
    vectors++;
    load = 1'b0;
    tick();
    if (led !== 16'h003E) begin miscompares++; $display("FAIL load_after led=%h expected=%h", led, 16'h003E); end
    vectors++;
  endtask

  task automatic test_async_reset();
    do_reset(5'd3);
    mode = 2'b00;
    en   = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    if (led !== 16'h00E0) begin miscompares++; $display("FAIL arst_pre led=%h expected=%h", led, 16'h00E0); end
    vectors++;
    #2;
    len = 5'd6;
    rst = 1'b1;
    #1;
    if (led !== 16'h003F) begin miscompares++; $display("FAIL arst_immediate led=%h expected=%h", led, 16'h003F); end
    vectors++;
    if (wrap !== 1'b0) begin miscompares++; $display("FAIL arst_wrap wrap=%b expected=0", wrap); end
    vectors++;
    tick();
    if (led !== 16'h003F) begin miscompares++; $display("FAIL arst_hold led=%h expected=%h", led, 16'h003F); end
    vectors++;
    rst = 1'b0;
    tick();
    if (led !== 16'h007E) begin miscompares++; $display("FAIL arst_release led=%h expected=%h", led, 16'h007E); end
    vectors++;
  endtask

  initial begin
    test_reset();
    test_rotate_left();
    test_rotate_right();
    test_bounce();
    test_bounce_full();
    test_clamp();
    test_divider();
    test_load();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
